// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned INSTR_W    = 19;
    localparam int unsigned WORD_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        W0,
        W1,
        W2,
        CSUM,
        DONE,
        ERR
    } state_t;

    function automatic logic [INSTR_W-1:0] pack_word(
        input logic [2:0] b0_lo,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return {b0_lo, b1, b2};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes 19-bit words
// into instruction memory, keeping the CPU in reset until the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t          state;
    // [15:8] holds LEN_HI while in LEN_LO; [10:8] and [7:0] hold B0[2:0] and B1 while assembling
    logic [15:0]     hold;
    logic [7:0]      csum;
    logic [ADDR_W:0] words_left;

    logic            accept;
    logic [15:0]     len_word;
    logic            len_ok;

    assign rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == W0) ||
                      (state == W1)     || (state == W2)     || (state == CSUM);
    assign busy     = rx_ready;
    assign accept   = rx_valid & rx_ready;
    assign len_word = {hold[15:8], rx_data};
    assign len_ok   = (len_word != 16'h0000) && ({1'b0, len_word} <= MAX_WORDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            csum       <= '0;
            words_left <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) begin
                imem_addr <= imem_addr + 1'b1;
            end

            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_HI;
                        hold       <= '0;
                        csum       <= '0;
                        words_left <= '0;
                        imem_addr  <= '0;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        hold[15:8] <= rx_data;
                        csum       <= csum + rx_data;
                        state      <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        csum <= csum + rx_data;
                        if (len_ok) begin
                            words_left <= len_word[ADDR_W:0];
                            state      <= W0;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                W0: begin
                    if (accept) begin
                        csum <= csum + rx_data;
                        if (rx_data[7:3] == 5'd0) begin
                            hold[10:8] <= rx_data[2:0];
                            state      <= W1;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                W1: begin
                    if (accept) begin
                        csum      <= csum + rx_data;
                        hold[7:0] <= rx_data;
                        state     <= W2;
                    end
                end
                W2: begin
                    if (accept) begin
                        csum       <= csum + rx_data;
                        imem_we    <= 1'b1;
                        imem_wdata <= pack_word(hold[10:8], hold[7:0], rx_data);
                        words_left <= words_left - 1'b1;
                        state      <= (words_left == (ADDR_W+1)'(1)) ? CSUM : W0;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            state     <= DONE;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined 19-bit processor. It accepts a checksummed byte stream over a valid/ready interface and packs it into 19-bit instruction words. It writes those words sequentially into the instruction memory's write port, holding the processor in reset until a complete, verified image is loaded. It is the write end of the instruction-memory port that the processor's fetch stage reads.

## Interface
- ADDR_W, 8, instruction-memory address width; supports up to 2^ADDR_W words
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; pure decode of the state register, no path from rx_valid
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  19  instruction word
- cpu_reset  out  1  processor reset; high unless the state is DONE
- busy  out  1  load in progress
- done  out  1  image loaded and checksum matched; sticky until start or reset
- error  out  1  load aborted; sticky until start or reset

## Operation
- Frame format, all multi-byte fields big-endian:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words of 3 bytes each (B0 B1 B2); word = {B0[2:0], B1, B2}.
  - CSUM: one byte equal to the sum mod 256 of every preceding frame byte.
- A byte is accepted on any edge with rx_valid & rx_ready.
- States, with the condition that leaves each:
  - IDLE: start → LEN_HI.
  - LEN_HI: byte accepted → LEN_LO.
  - LEN_LO: byte accepted → W0 if 1 ≤ N ≤ 2^ADDR_W, else → ERR.
  - W0: byte accepted → W1 if B0[7:3]==0, else → ERR.
  - W1: byte accepted → W2.
  - W2: byte accepted → W0 if words remain, else → CSUM.
  - CSUM: byte accepted → DONE if it equals the sum, else → ERR.
  - DONE, ERR: start → LEN_HI.
- start restarts the load:
  - It clears done, error, imem_addr, the checksum accumulator and the word counter, and raises cpu_reset.
  - start in LEN_HI through CSUM is ignored.
- Word counter is ADDR_W+1 bits, loaded with N at LEN_LO and decremented on each word written.
- imem_addr starts at 0 and increments after each write. It does not wrap, because N is bounded to 2^ADDR_W.
- rx_ready is 1 in LEN_HI, LEN_LO, W0, W1, W2 and CSUM; 0 in IDLE, DONE and ERR.
- busy is 1 in LEN_HI through CSUM.
- Words already written before an error or a reset stay in memory; they are not rolled back.

## Timing
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, error 0; state IDLE.
- Word write latency:
  - imem_we and imem_wdata are registered and asserted for exactly the one cycle after the B2 acceptance edge.
  - imem_addr holds the write address during that cycle and increments at the end of it.
- Throughput: one byte per cycle when rx_valid is held high. rx_valid gaps stall the loader without side effects.
- Last word then checksum: the final imem_we pulse and rx_ready in CSUM occur in the same cycle. The CSUM byte may be accepted on that cycle.
- done rises and cpu_reset falls on the same edge that accepts a matching CSUM.
- error rises on the edge that accepts the offending byte. The offending byte is consumed, and rx_ready drops on the next cycle.
- Reset asserted mid-load returns all outputs to their reset values immediately (asynchronously). A partially assembled word is discarded and imem_we never fires for it.

## Structure
- Shared package imem_loader_pkg holds:
  - state encoding constants IDLE, LEN_HI, LEN_LO, W0, W1, W2, CSUM, DONE, ERR
  - INSTR_W = 19
  - WORD_BYTES = 3
- Single module with no sub-modules; the byte assembler is a 16-bit holding register (B0[2:0], B1) inside the FSM.

## Test plan
- Nominal load of N=2 with stream 00 02 00 00 01 07 FF FF 08:
  - writes 0x00001 at address 0 and 0x7FFFF at address 1
  - done=1, cpu_reset=0, error=0
- Same stream with rx_valid toggling every other cycle:
  - identical writes
  - exactly 2 imem_we pulses
  - no acceptance while rx_valid=0
- Same stream with checksum byte 09: error=1, done=0, cpu_reset=1, rx_ready=0 afterwards; both words are still written.
- Stream 00 00 (N=0): error after the second byte, no imem_we. Stream 00 01 08 …: error on B0=0x08, no imem_we.
- Reset for one cycle after 5 bytes of the nominal stream, then start plus the full stream: a single clean load with writes starting at address 0.
- start pulse during busy: ignored. start in DONE: done clears, cpu_reset rises, and a second image overwrites from address 0.
